period_meter: RTL

Measures the period of a slow, divider-generated tick such as the 10 Hz game tick, counted in `clk_25MHz` cycles, and checks it against an expected value. It sits downstream of the clock divider in the ball design and consumes the tick the divider produces. It reports every measured period with a one-cycle valid pulse, flags out-of-tolerance periods, and detects a stalled tick.

---
 rtl/period_meter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/period_meter.sv
// period_meter: measures the tick_in period in clk_25MHz cycles; flags tolerance, lock and loss.
// Min/max statistics are built only when PERIOD_METER_MINMAX_EN is defined.
module period_meter #(
  parameter int CNT_W      = 24,
  parameter int EXP_PERIOD = 2500000,
  parameter int TOL        = 25000,
  parameter int TIMEOUT    = 5000000
) (
  input  logic             clk_25MHz,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             locked,
  output logic             lost,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period
);

  // Bounds held one bit wider than the counter so EXP_PERIOD+TOL cannot wrap.
  localparam logic [CNT_W:0]   LO_BOUND = (CNT_W+1)'((EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0);
  localparam logic [CNT_W:0]   HI_BOUND = (CNT_W+1)'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, LOST} state_t;

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             prev;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lock_cnt;
  logic [CNT_W:0]   meas;
  logic [CNT_W-1:0] new_period;
  logic             new_in_range;

  always_comb begin
    rise         = sync2 & ~prev;
    meas         = {1'b0, cnt} + (CNT_W+1)'(1);
    new_period   = meas[CNT_W] ? '1 : meas[CNT_W-1:0];
    new_in_range = ({1'b0, new_period} >= LO_BOUND) && ({1'b0, new_period} <= HI_BOUND);
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      prev         <= 1'b0;
      state        <= IDLE;
      cnt          <= '0;
      lock_cnt     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      sync1        <= tick_in;
      sync2        <= sync1;
      prev         <= sync2;
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            cnt   <= '0;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          // A rise wins over a timeout on the same edge, allowing period == TIMEOUT.
          if (rise) begin
            cnt          <= '0;
            period       <= new_period;
            period_valid <= 1'b1;
            in_range     <= new_in_range;
            if (new_in_range) begin
              lock_cnt <= (lock_cnt == 2'd2) ? 2'd2 : lock_cnt + 2'd1;
              locked   <= (lock_cnt != 2'd0);
            end else begin
              lock_cnt <= '0;
              locked   <= 1'b0;
            end
          end else if (cnt == TMO_LAST) begin
            state    <= LOST;
            lost     <= 1'b1;
            lock_cnt <= '0;
            locked   <= 1'b0;
          end else begin
            cnt <= (cnt == '1) ? cnt : cnt + CNT_W'(1);
          end
        end
        LOST: begin
          if (rise) begin
            cnt   <= '0;
            lost  <= 1'b0;
            state <= MEASURE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PERIOD_METER_MINMAX_EN
  // A clear coinciding with a new period restarts the statistics from that period.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      min_period <= '1;
      max_period <= '0;
    end else if (state == MEASURE && rise) begin
      min_period <= (clr_stats || new_period < min_period) ? new_period : min_period;
      max_period <= (clr_stats || new_period > max_period) ? new_period : max_period;
    end else if (clr_stats) begin
      min_period <= '1;
      max_period <= '0;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_stats;
  assign min_period = '0;
  assign max_period = '0;
`endif

endmodule
